// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Timing: ack one cycle after grant, done ALU_LAT+1 cycles after grant; ALU_ARB_LOCK_EN adds lock0/lock1 priority hold.
module alu_share_arb #(
   parameter int WIDTH   = 4,
   parameter int OPW     = 3,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0,
   input  logic [OPW-1:0]   op0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             ack0,
   output logic             done0,
   input  logic             req1,
   input  logic [OPW-1:0]   op1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack1,
   output logic             done1,
`ifdef ALU_ARB_LOCK_EN
   input  logic             lock0,
   input  logic             lock1,
`endif
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [3:0]       alu_flags,
   output logic             busy
);

   if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_chk
      $error("alu_share_arb: ALU_LAT must be in 1..15");
   end

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   state_t     state;
   logic       ptr;
   logic       owner;
   logic [3:0] cnt;
   logic       pick_vld;
   logic       pick;
   logic       keep_owner;

   // With both requests up the pointer decides; otherwise the lone requester wins.
   always_comb begin
      pick_vld = req0 | req1;
      pick     = (req0 & req1) ? ptr : req1;
   end

`ifdef ALU_ARB_LOCK_EN
   assign keep_owner = owner ? lock1 : lock0;
`else
   assign keep_owner = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         ptr    <= 1'b0;
         owner  <= 1'b0;
         cnt    <= '0;
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         busy   <= 1'b0;
         result <= '0;
         flags  <= '0;
         alu_op <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
      end else begin
         ack0  <= 1'b0;
         ack1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  owner  <= pick;
                  alu_op <= pick ? op1 : op0;
                  alu_a  <= pick ? a1 : a0;
                  alu_b  <= pick ? b1 : b0;
                  ack0   <= ~pick;
                  ack1   <= pick;
                  cnt    <= LAT_M1;
                  busy   <= 1'b1;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  result <= alu_result;
                  flags  <= alu_flags;
                  done0  <= ~owner;
                  done1  <= owner;
                  state  <= DONE;
               end
            end
            DONE: begin
               ptr   <= keep_owner ? owner : ~owner;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: two lanes (ALU_LAT=1 and ALU_LAT=4), each with a stub ALU,
// directed cases, then randomized contention checked by a cycle-level scoreboard.
`timescale 1ns/1ps
module tb_alu_share_arb;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: returns {c,n,z,v,result}.
   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      logic       v;
      s = 5'd0;
      v = 1'b0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; v = (a[3] == b[3]) && (s[3] != a[3]); end
         3'd1: begin s = {1'b0, a} - {1'b0, b}; v = (a[3] != b[3]) && (s[3] != a[3]); end
         3'd2: s = {1'b0, a & b};
         3'd3: s = {1'b0, a | b};
         3'd4: s = {1'b0, a ^ b};
         3'd5: s = {1'b0, ~a};
         3'd6: s = {a, 1'b0};
         default: s = {1'b0, b};
      endcase
      return {s[4], s[3], (s[3:0] == 4'd0), v, s[3:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int LAT = (g == 0) ? 1 : 4;

      logic       rst_n;
      logic       req_s [2];
      logic [2:0] op_s [2];
      logic [3:0] a_s [2];
      logic [3:0] b_s [2];
      logic       lock_s [2];
      logic       ack0, ack1, done0, done1, busy;
      logic [3:0] result, flags, alu_a, alu_b, alu_result, alu_flags;
      logic [2:0] alu_op;
      logic [10:0] opq0 [$];
      logic [10:0] opq1 [$];
      logic [7:0]  resq0 [$];
      logic [7:0]  resq1 [$];
      bit fin = 1'b0;

      assign {alu_flags, alu_result} = alu_f(alu_op, alu_a, alu_b);

      alu_share_arb #(.WIDTH(4), .OPW(3), .ALU_LAT(LAT)) u_dut (
         .clk(clk), .reset_n(rst_n),
         .req0(req_s[0]), .op0(op_s[0]), .a0(a_s[0]), .b0(b_s[0]), .ack0(ack0), .done0(done0),
         .req1(req_s[1]), .op1(op_s[1]), .a1(a_s[1]), .b1(b_s[1]), .ack1(ack1), .done1(done1),
`ifdef ALU_ARB_LOCK_EN
         .lock0(lock_s[0]), .lock1(lock_s[1]),
`endif
         .result(result), .flags(flags), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
         .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
      );

      task automatic issue(input int r, input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                           input logic lk);
         op_s[r] = o; a_s[r] = x; b_s[r] = y; lock_s[r] = lk; req_s[r] = 1'b1;
         if (r == 0) begin
            opq0.push_back({o, x, y});
            resq0.push_back(alu_f(o, x, y));
         end else begin
            opq1.push_back({o, x, y});
            resq1.push_back(alu_f(o, x, y));
         end
      endtask

      task automatic wait_ack(input int r, output int cyc);
         bit seen = 1'b0;
         cyc = 0;
         while (!seen && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            seen = (r == 0) ? ack0 : ack1;
         end
         if (!seen) begin
            checks++; errors++;
            $display("FAIL L%0d ack%0d timeout: got none within %0d cycles", g, r, cyc);
         end
      endtask

      task automatic wait_done(input int r);
         bit seen = 1'b0;
         int cyc = 0;
         while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            seen = (r == 0) ? done0 : done1;
         end
         if (!seen) begin
            checks++; errors++;
            $display("FAIL L%0d done%0d timeout: got none within %0d cycles", g, r, cyc);
         end
      endtask

      task automatic run_req(input int r, input int n, input int max_gap);
         int cyc;
         int gap;
         for (int k = 0; k < n; k++) begin
            issue(r, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
            wait_ack(r, cyc);
            if (cyc >= 100) break;
            // operands move on right after acceptance; the DUT must not follow them
            op_s[r] = 3'($urandom); a_s[r] = 4'($urandom); b_s[r] = 4'($urandom);
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            if (gap > 0) begin
               req_s[r] = 1'b0;
               repeat (gap) @(posedge clk);
               #1;
            end
         end
         req_s[r] = 1'b0;
      endtask

      // Scoreboard: model the protocol cycle by cycle from requests alone.
      bit in_op = 1'b0, was_done = 1'b0, rr = 1'b0, owner = 1'b0, p_req0 = 1'b0, p_req1 = 1'b0;
      int elapsed = 0;
      logic [10:0] cur_ops = '0;
      always @(negedge clk) begin
         bit exp_ack, who, exp_done;
         logic [7:0] exp_res;
         if (!rst_n) begin
            in_op = 1'b0; was_done = 1'b0; rr = 1'b0; p_req0 = 1'b0; p_req1 = 1'b0;
            opq0.delete(); opq1.delete(); resq0.delete(); resq1.delete();
         end else begin
            exp_ack = !in_op && (p_req0 || p_req1);
            who     = (p_req0 && p_req1) ? rr : p_req1;
            chk($sformatf("L%0d ack0", g), 32'(ack0), 32'(exp_ack && !who));
            chk($sformatf("L%0d ack1", g), 32'(ack1), 32'(exp_ack && who));
            if (exp_ack) begin
               in_op = 1'b1; owner = who; elapsed = 0;
               if ((who ? opq1.size() : opq0.size()) == 0) begin
                  checks++; errors++;
                  $display("FAIL L%0d grant: got grant to %0d expected no pending op", g, who);
               end else begin
                  cur_ops = who ? opq1.pop_front() : opq0.pop_front();
                  chk($sformatf("L%0d alu_inputs", g), 32'({alu_op, alu_a, alu_b}), 32'(cur_ops));
               end
            end else if (was_done) begin
               in_op = 1'b0;
            end else if (in_op) begin
               elapsed++;
               chk($sformatf("L%0d alu_hold", g), 32'({alu_op, alu_a, alu_b}), 32'(cur_ops));
            end
            was_done = 1'b0;
            exp_done = in_op && (elapsed == LAT);
            chk($sformatf("L%0d done0", g), 32'(done0), 32'(exp_done && !owner));
            chk($sformatf("L%0d done1", g), 32'(done1), 32'(exp_done && owner));
            chk($sformatf("L%0d busy", g), 32'(busy), 32'(in_op));
            if (exp_done) begin
               if ((owner ? resq1.size() : resq0.size()) == 0) begin
                  checks++; errors++;
                  $display("FAIL L%0d result: got done for %0d expected no pending result", g, owner);
               end else begin
                  exp_res = owner ? resq1.pop_front() : resq0.pop_front();
                  chk($sformatf("L%0d result_flags", g), 32'({flags, result}), 32'(exp_res));
               end
`ifdef ALU_ARB_LOCK_EN
               rr = lock_s[owner] ? owner : !owner;
`else
               rr = !owner;
`endif
               was_done = 1'b1;
            end
            p_req0 = req_s[0];
            p_req1 = req_s[1];
         end
      end

      initial begin
         int cyc;
         rst_n = 1'b0;
         for (int r = 0; r < 2; r++) begin
            req_s[r] = 1'b0; op_s[r] = '0; a_s[r] = '0; b_s[r] = '0; lock_s[r] = 1'b0;
         end
         repeat (3) @(posedge clk); #1;
         chk($sformatf("L%0d reset_ctl", g), 32'({ack0, ack1, done0, done1, busy}), 32'd0);
         chk($sformatf("L%0d reset_dat", g), 32'({result, flags, alu_op, alu_a, alu_b}), 32'd0);
         rst_n = 1'b1;
         @(posedge clk); #1;

         // single add 5+6
         issue(0, 3'd0, 4'h5, 4'h6, 1'b0);
         wait_ack(0, cyc);
         chk($sformatf("L%0d single_ack_lat", g), 32'(cyc), 32'd1);
         chk($sformatf("L%0d single_ops", g), 32'({alu_a, alu_b}), 32'h56);
         req_s[0] = 1'b0; a_s[0] = 4'hA;
         wait_done(0);
         chk($sformatf("L%0d single_result", g), 32'(result), 32'hB);
         chk($sformatf("L%0d single_z", g), 32'(flags[1]), 32'd0);

         // carry-out to zero on requester 1
         issue(1, 3'd0, 4'hF, 4'h1, 1'b0);
         wait_ack(1, cyc);
         req_s[1] = 1'b0;
         wait_done(1);
         chk($sformatf("L%0d carry_result", g), 32'(result), 32'h0);
         chk($sformatf("L%0d carry_flags", g), 32'(flags), 32'b1010);

         // reset while an operation is in flight
         issue(0, 3'd1, 4'h3, 4'h9, 1'b0);
         wait_ack(0, cyc);
         req_s[0] = 1'b0;
         if (LAT > 1) begin @(posedge clk); #1; end
         rst_n = 1'b0;
         #1;
         chk($sformatf("L%0d abort_ctl", g), 32'({ack0, ack1, done0, done1, busy}), 32'd0);
         chk($sformatf("L%0d abort_dat", g), 32'({result, flags, alu_op, alu_a, alu_b}), 32'd0);
         repeat (2) @(posedge clk); #1;
         rst_n = 1'b1;
         issue(1, 3'd4, 4'h6, 4'h3, 1'b0);
         wait_ack(1, cyc);
         chk($sformatf("L%0d post_reset_ack1", g), 32'(cyc), 32'd1);
         req_s[1] = 1'b0;
         wait_done(1);

         // continuous contention, then random traffic
         fork
            run_req(0, 12, 0);
            run_req(1, 12, 0);
         join
         fork
            run_req(0, 30, 3);
            run_req(1, 30, 3);
         join
         for (int t = 0; t < 200 && (resq0.size() != 0 || resq1.size() != 0 || busy); t++) begin
            @(posedge clk); #1;
         end
         chk($sformatf("L%0d drained", g), 32'(resq0.size() + resq1.size()), 32'd0);
         fin = 1'b1;
      end
   end

   initial begin
      for (int t = 0; t < 20000 && !(g_lane[0].fin && g_lane[1].fin); t++) @(posedge clk);
      if (!(g_lane[0].fin && g_lane[1].fin)) begin
         checks++; errors++;
         $display("FAIL global_timeout: got lanes unfinished expected both finished");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one combinational ALU datapath (alu4 class) between two requesters.
- Grants one requester at a time and registers its operands and opcode onto the ALU inputs.
- Holds those inputs stable for ALU_LAT cycles, then captures result and flags and returns them to the granted requester with a one-cycle done pulse.
- Sits between the ALU instance and the two client blocks (e.g. sequencer and test/IO path).

Parameters:
WIDTH, 4, operand/result width
OPW, 3, opcode width
ALU_LAT, 1, cycles ALU inputs are held before capture; legal 1..15

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 request
op0  input  OPW  requester 0 opcode
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B
ack0  output  1  one-cycle pulse: requester 0 operands accepted
done0  output  1  one-cycle pulse: result valid for requester 0
req1, op1, a1, b1, ack1, done1  same widths/meaning for requester 1
result  output  WIDTH  registered result, valid while done0 or done1 is high
flags  output  4  registered {c,n,z,v}, valid with result
alu_op  output  OPW  registered opcode to ALU
alu_a  output  WIDTH  registered operand A to ALU
alu_b  output  WIDTH  registered operand B to ALU
alu_result  input  WIDTH  ALU combinational result
alu_flags  input  4  ALU combinational {c,n,z,v}
busy  output  1  high in EXEC and DONE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, priority pointer=requester 0.
  - All outputs 0; latency counter 0.
- States IDLE, EXEC, DONE.
- IDLE, no req: stay in IDLE.
- IDLE, one req high: grant it.
- IDLE, both req high: grant the requester named by the priority pointer.
- Grant at edge E:
  - alu_op/alu_a/alu_b load the granted requester's op/a/b.
  - ack_x=1 for the cycle after E.
  - Counter loads ALU_LAT-1; state goes to EXEC.
- EXEC:
  - alu_* held constant.
  - Counter nonzero: decrement.
  - Counter 0: result<=alu_result, flags<=alu_flags, state goes to DONE.
- DONE:
  - done_x=1 for exactly one cycle.
  - Priority pointer moves to the other requester; next edge goes to IDLE.
- Latency: req sampled at edge E gives ack_x high in cycle E+1 and done_x high in cycle E+ALU_LAT+1.
- Back-to-back throughput: one operation per ALU_LAT+2 cycles.
- Requester rules:
  - Keep req, op, a and b stable until ack.
  - Requests arriving during EXEC/DONE are not sampled until IDLE.
  - req still high in IDLE after done counts as a new request.
- result/flags hold their last value outside done; alu_* hold their last value in IDLE.
- ack and done are never both high for the same requester in one cycle.
- At most one of ack0/ack1, and at most one of done0/done1, is high.
- Reset during EXEC/DONE aborts the operation: no done pulse, outputs cleared immediately.
- ALU_LAT outside 1..15 is unsupported (elaboration check when possible).

Optional Feature:
- Macro ALU_ARB_LOCK_EN.
- Defined:
  - Adds input ports lock0 and lock1 (1 bit each).
  - If the granted requester has lock_x=1 in the DONE cycle, the priority pointer stays on that requester, not the other one.
  - That requester wins the next IDLE arbitration if its req is high, even when both req are high.
  - A lock seen at grant but dropped by DONE has no effect.
- Not defined:
  - No lock ports.
  - Pure round-robin as above.

Test Plan:
- Reset: reset_n=0 mid-EXEC -> all outputs 0 at once, no done; after release req1 alone is granted, ack1 in the next cycle.
- Single request: ALU_LAT=1, req0, op0=3'b000 (add), a0=4'h5, b0=4'h6 -> ack0 at E+1, alu_a=5, alu_b=6, done0 at E+2, result=4'hB, flags z=0.
- Contention: req0 and req1 both held high continuously -> grants alternate 0,1,0,1; done pulses never overlap; one done per 3 cycles.
- Latency: ALU_LAT=4 -> done at E+5; alu_a/alu_b/alu_op constant across all 4 EXEC cycles; a0 changed after ack does not alter result.
- Flags: req1 with a1=4'hF, b1=4'h1, add -> result=4'h0, flags c=1, z=1, delivered on done1 only.
- ALU_ARB_LOCK_EN defined: lock0=1 with req0/req1 both high -> requester 0 granted twice in a row; lock0=0 -> requester 1 granted next.
